bram_port_arbiter: RTL and testbench
====================================

// Module: bram_port_arbiter
// PURPOSE
//  Shares port A of the 8192x8 dual-port block RAM (Gowin_DPB_8k) between two requesters (req0, req1).
//  Uses round-robin arbitration and a valid/ready handshake, and routes read data back to the owner.
//  Contains a fill engine that writes FILL to all 8192 locations after reset or on command.
//  Sits between the platform bus masters and the RAM macro; port B stays outside this block.
// PARAMETERS
//  ADDR_W         13     RAM address width (depth = 2**ADDR_W)
//  DATA_W         8      RAM data width
//  FILL           8'h00  value written by the fill engine
//  INIT_ON_RESET  1      1: fill engine runs on reset release; 0: block starts in IDLE
// PORTS
//  clk          in   1       single clock; also drives ram clka
//  rst_n        in   1       async active-low reset
//  init_start   in   1       1-cycle pulse: start fill (ignored while init_busy)
//  init_busy    out  1       fill engine running
//  init_done    out  1       sticky: set when a fill completes, cleared by init_start
//  reqN_valid   in   1       request valid (N = 0,1)
//  reqN_ready   out  1       request accepted this cycle when valid & ready
//  reqN_we      in   1       1 = write, 0 = read
//  reqN_addr    in   ADDR_W  word address
//  reqN_wdata   in   DATA_W  write data
//  reqN_rvalid  out  1       read data valid (reads only)
//  reqN_rdata   out  DATA_W  read data; 0 when reqN_rvalid = 0
//  ram_cea      out  1       to RAM cea
//  ram_wrea     out  1       to RAM wrea
//  ram_ocea     out  1       tied 1
//  ram_reseta   out  1       tied 0
//  ram_ada      out  ADDR_W  to RAM ada
//  ram_dina     out  DATA_W  to RAM dina
//  ram_douta    in   DATA_W  from RAM douta (bypass read mode: valid 1 cycle after cea)
// BEHAVIOUR
//  States
//   - FILL, IDLE.
//   - Reset state: FILL if INIT_ON_RESET, else IDLE.
//  Reset values
//   - init_busy = INIT_ON_RESET, init_done = 0, rvalid = 0, rdata = 0.
//   - readies = 0, prio = req0, fill counter = 0.
//  FILL
//   - Drives ram_cea = 1, ram_wrea = 1, ram_ada = cnt, ram_dina = FILL. One word per cycle.
//   - Both readies = 0.
//   - At cnt = 2**ADDR_W-1: go to IDLE next cycle, clear init_busy, set init_done, reset cnt to 0.
//   - A fill takes exactly 8192 cycles.
//  IDLE to FILL
//   - init_start = 1 in IDLE forces both readies = 0 in that cycle.
//   - FILL begins next cycle, with init_done cleared.
//  IDLE arbitration (combinational grant)
//   - Only one valid: that requester is granted.
//   - Both valid: the requester named by prio is granted; the other waits with ready = 0.
//   - On each accepted transfer, prio flips to the non-granted requester.
//   - With no accept, prio holds.
//  Granted request drives the RAM in the same cycle
//   - ram_cea = 1, ram_wrea = we, ram_ada = addr, ram_dina = wdata.
//   - No grant: ram_cea = 0, ram_wrea = 0; ram_ada/ram_dina hold last value (no toggling).
//  Read return
//   - Registered owner flag: reqN_rvalid = 1 exactly 1 cycle after the accepted read.
//   - reqN_rdata = ram_douta in that cycle.
//   - Writes never produce rvalid.
//  Throughput
//   - One accepted transfer per cycle, back-to-back.
//   - A read and the next request may overlap (rvalid of read k coincides with accept of k+1).
//  Requester rule: valid/addr/we/wdata stay stable until ready. The arbiter does not check this.
//  rst_n assert mid-fill or mid-read: immediate return to reset values; a pending rvalid is dropped.
//  init_start while init_busy: ignored, counter not restarted.
// STRUCTURE
//  Shared include bram_arb_defs.vh
//   - State encodings ST_FILL/ST_IDLE and default ADDR_W/DATA_W.
//   - Reused by the port-B side and the testbench.
//  Sub-module rr_arb2
//   - 2-way round-robin: valid[1:0] in, grant[1:0] out, prio flop, update on accept.
//  Top-level logic
//   - FILL/IDLE FSM, fill counter, RAM mux, rvalid owner pipeline.
//   - Instantiates Gowin_DPB_8k only in the wrapper, not in this block.
// TESTING
//  1. INIT_ON_RESET=1, release rst_n
//     -> init_busy high 8192 cycles, ram_ada 0..8191 with wrea=1 and dina=00.
//     -> init_done=1 the next cycle; readies 0 throughout.
//  2. After fill, req0 writes 0x1ABC <= 8'h5A, then reads 0x1ABC
//     -> req0_rvalid one cycle after the read accept, req0_rdata = 8'h5A.
//     -> a read of 0x0001 returns 8'h00.
//  3. req0 and req1 valid continuously, prio=req0
//     -> grants alternate 0,1,0,1; one accept per cycle; no starvation over 100 cycles.
//  4. Back-to-back reads: req1 @0x0010, then req0 @0x0011 (different data)
//     -> req1_rvalid then req0_rvalid on consecutive cycles, each with its own data.
//     -> the other requester's rvalid stays 0.
//  5. init_start pulse while req0 valid in IDLE
//     -> req0_ready 0 that cycle; full refill; req0 accepted the cycle after init_busy falls.
//  6. Assert rst_n at fill word 300 and during an outstanding read
//     -> outputs reset immediately, no rvalid.
//     -> fill restarts from address 0 after release.

Source files
------------

// File: rtl/bram_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter_pkg
// Shared definitions for the block-RAM port-A arbiter: the FILL/IDLE state
// encoding, default RAM geometry, and the two-way round-robin pick function
// used by the arbiter sub-module.
// Ports: none (package).
// -----------------------------------------------------------------------------
package bram_port_arbiter_pkg;

  localparam int ARB_ADDR_W = 13;
  localparam int ARB_DATA_W = 8;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_IDLE = 1'b1
  } arb_state_t;

  // Round-robin pick between two requesters. prio = 0 favours requester 0
  // when both are valid; a lone valid requester always wins.
  function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic prio);
    logic [1:0] pick;
    pick = 2'b00;
    if (valid == 2'b11) begin
      pick = prio ? 2'b10 : 2'b01;
    end else begin
      pick = valid;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter with a single priority flop. Grant is purely
// combinational from the valids; since a grant is only ever given to a valid
// requester, every grant is an accepted transfer and the priority flips to the
// requester that lost.
// Ports:
//   clk       in   clock
//   rst_n     in   async active-low reset (priority returns to requester 0)
//   i_enable  in   arbitration allowed this cycle (0 forces no grant)
//   i_valid   in   [1:0] request valids
//   o_grant   out  [1:0] one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arb2
  import bram_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  logic       r_prio;
  logic [1:0] w_grant;

  always_comb begin
    w_grant = 2'b00;
    if (i_enable) begin
      w_grant = rr_pick(i_valid, r_prio);
    end
  end

  // Priority points at whoever did not get the last accepted transfer;
  // idle cycles leave it untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio <= 1'b0;
    end else if (w_grant[0]) begin
      r_prio <= 1'b1;
    end else if (w_grant[1]) begin
      r_prio <= 1'b0;
    end
  end

  assign o_grant = w_grant;

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares port A of an 8192x8 dual-port block RAM between two requesters with
// round-robin arbitration and a valid/ready handshake, and steers read data
// back to the requester that issued the read. A fill engine writes FILL to
// every location after reset (INIT_ON_RESET) or on init_start.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   init_start / init_busy / init_done   fill command, running flag, sticky done
//   reqN_valid/ready/we/addr/wdata       request channel, N = 0,1
//   reqN_rvalid/rdata                    read return (rdata is 0 when not valid)
//   ram_cea/wrea/ocea/reseta/ada/dina    RAM port-A controls
//   ram_douta                            RAM read data, one cycle after cea
// -----------------------------------------------------------------------------
module bram_port_arbiter
  import bram_port_arbiter_pkg::*;
#(
  parameter int                ADDR_W        = ARB_ADDR_W,
  parameter int                DATA_W        = ARB_DATA_W,
  parameter logic [DATA_W-1:0] FILL          = '0,
  parameter bit                INIT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              ram_cea,
  output logic              ram_wrea,
  output logic              ram_ocea,
  output logic              ram_reseta,
  output logic [ADDR_W-1:0] ram_ada,
  output logic [DATA_W-1:0] ram_dina,
  input  logic [DATA_W-1:0] ram_douta
);

  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;
  localparam arb_state_t        ST_RESET  = INIT_ON_RESET ? ST_FILL : ST_IDLE;

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_rd_owner;
  logic [ADDR_W-1:0] r_ada_last;
  logic [DATA_W-1:0] r_dina_last;

  logic              w_fill;
  logic              w_enable;
  logic [1:0]        w_grant;
  logic              w_cea;
  logic              w_wrea;
  logic [ADDR_W-1:0] w_ada;
  logic [DATA_W-1:0] w_dina;

  assign w_fill = (r_state == ST_FILL);

  // An init_start pulse in IDLE blocks the arbiter in the same cycle so no
  // transfer slips in just before the refill begins; rst_n keeps the readies
  // low while reset is held even when the block resets into IDLE.
  assign w_enable = (r_state == ST_IDLE) && !init_start && rst_n;

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (w_enable),
    .i_valid  ({req1_valid, req0_valid}),
    .o_grant  (w_grant)
  );

  // FILL/IDLE control: one word per FILL cycle, the last address hands over
  // to IDLE with done set. init_start is only looked at in IDLE, so a pulse
  // during a fill cannot restart the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_busy  <= INIT_ON_RESET;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (init_start) begin
            r_state <= ST_FILL;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM port mux. Without a grant the address and data buses keep their last
  // driven value so they do not toggle while the RAM is disabled.
  always_comb begin
    w_cea  = 1'b0;
    w_wrea = 1'b0;
    w_ada  = r_ada_last;
    w_dina = r_dina_last;
    if (w_fill) begin
      w_cea  = 1'b1;
      w_wrea = 1'b1;
      w_ada  = r_cnt;
      w_dina = FILL;
    end else if (w_grant[0]) begin
      w_cea  = 1'b1;
      w_wrea = req0_we;
      w_ada  = req0_addr;
      w_dina = req0_wdata;
    end else if (w_grant[1]) begin
      w_cea  = 1'b1;
      w_wrea = req1_we;
      w_ada  = req1_addr;
      w_dina = req1_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ada_last  <= '0;
      r_dina_last <= '0;
    end else begin
      r_ada_last  <= w_ada;
      r_dina_last <= w_dina;
    end
  end

  // Owner of the read issued last cycle; the RAM answers one cycle after cea,
  // so this flag lines up with ram_douta. Writes never set it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_owner <= 2'b00;
    end else begin
      r_rd_owner <= w_grant & {~req1_we, ~req0_we};
    end
  end

  assign init_busy   = r_busy;
  assign init_done   = r_done;
  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];
  assign req0_rvalid = r_rd_owner[0];
  assign req1_rvalid = r_rd_owner[1];
  assign req0_rdata  = r_rd_owner[0] ? ram_douta : '0;
  assign req1_rdata  = r_rd_owner[1] ? ram_douta : '0;
  assign ram_cea     = w_cea;
  assign ram_wrea    = w_wrea;
  assign ram_ocea    = 1'b1;
  assign ram_reseta  = 1'b0;
  assign ram_ada     = w_ada;
  assign ram_dina    = w_dina;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Drives bram_port_arbiter against a behavioural RAM and checks every cycle
// against a transaction-level reference (shadow memory, round-robin priority
// bit, fill progress counter, pending-read record).
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int          AW    = 13;
  localparam int          DW    = 8;
  localparam int          DEPTH = 1 << AW;
  localparam logic [7:0]  FILLV = 8'h00;

  logic          clk;
  logic          rst_n;
  logic          init_start;
  logic          init_busy;
  logic          init_done;
  logic          req0_valid, req0_ready, req0_we, req0_rvalid;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_ready, req1_we, req1_rvalid;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          ram_cea, ram_wrea, ram_ocea, ram_reseta;
  logic [AW-1:0] ram_ada;
  logic [DW-1:0] ram_dina;
  logic [DW-1:0] ram_douta;

  int checks;
  int errors;

  bram_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .init_start  (init_start),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_rvalid (req0_rvalid),
    .req0_rdata  (req0_rdata),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_rvalid (req1_rvalid),
    .req1_rdata  (req1_rdata),
    .ram_cea     (ram_cea),
    .ram_wrea    (ram_wrea),
    .ram_ocea    (ram_ocea),
    .ram_reseta  (ram_reseta),
    .ram_ada     (ram_ada),
    .ram_dina    (ram_dina),
    .ram_douta   (ram_douta)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM port A, output valid one cycle after cea. Contents start
  // random so only a real fill makes them read back as FILLV.
  logic [DW-1:0] ramMem [DEPTH];
  logic [DW-1:0] ramDout;
  initial begin
    for (int i = 0; i < DEPTH; i++) ramMem[i] = 8'($urandom);
    ramDout = '0;
  end
  always @(posedge clk) begin
    if (ram_cea) begin
      if (ram_wrea) begin
        ramMem[ram_ada] <= ram_dina;
        ramDout         <= ram_dina;
      end else begin
        ramDout <= ramMem[ram_ada];
      end
    end
  end
  assign ram_douta = ramDout;

  // Reference model state
  logic [DW-1:0] shadow [DEPTH];
  bit            mFill;
  int            mCnt;
  bit            mPrio;
  bit            mDone;
  logic [1:0]    mPend;
  logic [DW-1:0] mPendData;
  logic [AW-1:0] mLastAda;
  logic [DW-1:0] mLastDin;
  logic [1:0]    mLastGrant;
  logic [1:0]    obsReady;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = 'x;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    mFill      = 1'b1;
    mCnt       = 0;
    mPrio      = 1'b0;
    mDone      = 1'b0;
    mPend      = 2'b00;
    mPendData  = '0;
    mLastAda   = '0;
    mLastDin   = '0;
    mLastGrant = 2'b00;
  endtask

  task automatic applyStimulus(input int n, input logic v, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = addr; req0_wdata = data;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = addr; req1_wdata = data;
    end
  endtask

  // Who the rules say gets the port this cycle.
  function automatic logic [1:0] modelGrant();
    logic [1:0] v;
    v = {req1_valid, req0_valid};
    if (mFill || init_start) return 2'b00;
    if (v == 2'b11) return mPrio ? 2'b10 : 2'b01;
    return v;
  endfunction

  // One clock: check all outputs at the falling edge, advance the model at
  // the rising edge, return 1 time unit later so callers can change inputs.
  task automatic stepCycle(input string tag);
    logic [1:0]    g;
    logic          eCea, eWe;
    logic [AW-1:0] eAda;
    logic [DW-1:0] eDin;
    logic [46:0]   obs, exp;
    int            sel;
    @(negedge clk);
    g = modelGrant();
    if (mFill) begin
      eCea = 1'b1; eWe = 1'b1; eAda = AW'(mCnt); eDin = FILLV;
    end else if (g[0]) begin
      eCea = 1'b1; eWe = req0_we; eAda = req0_addr; eDin = req0_wdata;
    end else if (g[1]) begin
      eCea = 1'b1; eWe = req1_we; eAda = req1_addr; eDin = req1_wdata;
    end else begin
      eCea = 1'b0; eWe = 1'b0; eAda = mLastAda; eDin = mLastDin;
    end
    exp = {1'b1, 1'b0, mFill, mDone, g, mPend,
           mPend[0] ? mPendData : 8'h00, mPend[1] ? mPendData : 8'h00,
           eCea, eWe, eAda, eDin};
    obs = {ram_ocea, ram_reseta, init_busy, init_done, req1_ready, req0_ready,
           req1_rvalid, req0_rvalid, req0_rdata, req1_rdata,
           ram_cea, ram_wrea, ram_ada, ram_dina};
    obsReady = {req1_ready, req0_ready};
    checkOutput(tag, 64'(obs), 64'(exp));
    @(posedge clk);
    mPend = 2'b00;
    if (mFill) begin
      shadow[mCnt] = FILLV;
      if (mCnt == DEPTH - 1) begin
        mFill = 1'b0; mDone = 1'b1; mCnt = 0;
      end else begin
        mCnt++;
      end
    end else if (init_start) begin
      mFill = 1'b1; mDone = 1'b0; mCnt = 0;
    end else if (g != 2'b00) begin
      sel = g[1] ? 1 : 0;
      if (sel == 0) begin
        if (req0_we) shadow[req0_addr] = req0_wdata;
        else begin mPend = 2'b01; mPendData = shadow[req0_addr]; end
      end else begin
        if (req1_we) shadow[req1_addr] = req1_wdata;
        else begin mPend = 2'b10; mPendData = shadow[req1_addr]; end
      end
      mPrio = (sel == 0);
    end
    mLastAda   = eAda;
    mLastDin   = eDin;
    mLastGrant = g;
    #1;
  endtask

  // Hold a request until the model grants it, then drop valid.
  task automatic issue(input int n, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bit acc;
    acc = 1'b0;
    applyStimulus(n, 1'b1, we, addr, data);
    for (int k = 0; k < 20000 && !acc; k++) begin
      stepCycle("issue");
      if (mLastGrant[n]) acc = 1'b1;
    end
    applyStimulus(n, 1'b0, 1'b0, '0, '0);
    checkOutput("issue_accepted", 64'(acc), 64'd1);
  endtask

  task automatic newPayload(input int n, input logic v);
    applyStimulus(n, v, 1'($urandom_range(0, 1)), AW'(13'h100 + $urandom_range(0, 15)), 8'($urandom));
  endtask

  task automatic runFill(input string tag);
    for (int i = 0; i < DEPTH; i++) stepCycle(tag);
    checkOutput({tag, "_done"}, 64'({init_busy, init_done}), 64'(2'b01));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput(tag, 64'({init_busy, init_done, req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                          req0_rdata, req1_rdata, ram_ada}),
                     64'({1'b1, 1'b0, 4'b0000, 16'h0000, 13'h0000}));
  endtask

  task automatic pulseReset();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("reset_immediate");
    @(posedge clk);
    #1;
    checkResetOutputs("reset_held");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resetModel();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int g0, g1;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    init_start = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    resetModel();
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset_state");
    rst_n = 1'b1;

    // 1: fill after reset release
    runFill("t1_fill");

    // 2: write then read back, plus a filled location
    issue(0, 1'b1, 13'h1ABC, 8'h5A);
    issue(0, 1'b0, 13'h1ABC, 8'h00);
    checkOutput("t2_rd_5a", 64'({req0_rvalid, req1_rvalid, req0_rdata}), 64'({1'b1, 1'b0, 8'h5A}));
    issue(0, 1'b0, 13'h0001, 8'h00);
    checkOutput("t2_rd_fill", 64'({req0_rvalid, req0_rdata}), 64'({1'b1, 8'h00}));

    // 3: both requesters valid continuously, priority starting at req0
    issue(1, 1'b1, 13'h0200, 8'h33);
    newPayload(0, 1'b1);
    newPayload(1, 1'b1);
    g0 = 0; g1 = 0;
    for (int i = 0; i < 100; i++) begin
      stepCycle("t3_rr");
      g0 += int'(obsReady[0]);
      g1 += int'(obsReady[1]);
      if (mLastGrant[0]) newPayload(0, 1'b1);
      if (mLastGrant[1]) newPayload(1, 1'b1);
    end
    checkOutput("t3_grants0", 64'(g0), 64'd50);
    checkOutput("t3_grants1", 64'(g1), 64'd50);
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    stepCycle("t3_drain");

    // 4: back-to-back reads from different owners
    issue(1, 1'b1, 13'h0010, 8'hA1);
    issue(0, 1'b1, 13'h0011, 8'hB2);
    issue(1, 1'b0, 13'h0010, 8'h00);
    checkOutput("t4_rd1", 64'({req1_rvalid, req0_rvalid, req1_rdata}), 64'({1'b1, 1'b0, 8'hA1}));
    issue(0, 1'b0, 13'h0011, 8'h00);
    checkOutput("t4_rd0", 64'({req0_rvalid, req1_rvalid, req0_rdata}), 64'({1'b1, 1'b0, 8'hB2}));

    // Randomized traffic obeying the hold-until-ready rule
    newPayload(0, 1'($urandom_range(0, 1)));
    newPayload(1, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1500; i++) begin
      stepCycle("rand");
      if (!req0_valid || mLastGrant[0]) newPayload(0, ($urandom_range(0, 3) != 0));
      if (!req1_valid || mLastGrant[1]) newPayload(1, ($urandom_range(0, 3) != 0));
    end
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    stepCycle("rand_drain");

    // 5: init_start with req0 pending, second pulse mid-fill is ignored
    begin
      int n;
      bit acc;
      n = 0;
      acc = 1'b0;
      applyStimulus(0, 1'b1, 1'b1, 13'h0042, 8'hC3);
      while (n < 9000 && !acc) begin
        init_start = (n == 0 || n == 100);
        stepCycle("t5_refill");
        n++;
        if (mLastGrant[0]) acc = 1'b1;
      end
      init_start = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, '0, '0);
      checkOutput("t5_accept_cycle", 64'(n), 64'd8194);
    end
    issue(1, 1'b0, 13'h0042, 8'h00);
    checkOutput("t5_rd", 64'({req1_rvalid, req1_rdata}), 64'({1'b1, 8'hC3}));

    // 6a: reset while a read return is pending
    issue(0, 1'b0, 13'h0042, 8'h00);
    #1;
    pulseReset();

    // 6b: reset at fill word 300, then a clean fill from address 0
    for (int i = 0; i < 300; i++) stepCycle("t6_partial");
    #1;
    pulseReset();
    runFill("t6_fill");
    issue(0, 1'b0, 13'h012C, 8'h00);
    checkOutput("t6_rd", 64'({req0_rvalid, req0_rdata}), 64'({1'b1, 8'h00}));
    stepCycle("t6_tail");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
